decoder_scan_ctrl: RTL and testbench

DECODER_SCAN_CTRL -- requirements
Module: decoder_scan_ctrl

---
 rtl/decoder_scan_ctrl_pkg.sv | 15 +
 rtl/decoder_scan_ctrl_next_channel_pick.sv | 30 +++
 rtl/decoder_scan_ctrl.sv | 119 +++++++++++
 tb/tb_decoder_scan_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared types and defaults for the decoder scan controller.
// No logic; purely declarative, so no latency or flow control applies.
package decoder_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DWELL = 2'd2
  } state_e;

  localparam int unsigned DWELL_CYCLES_DEF = 8;
  localparam int unsigned BLANK_CYCLES_DEF = 2;
  localparam int unsigned CNT_W            = 8;

endpackage

// File: rtl/decoder_scan_ctrl_next_channel_pick.sv
// Next-channel search: first set mask bit strictly above cur_sel, modulo 4.
// Purely combinational (zero latency); no flow control.
module next_channel_pick (
  input  logic [3:0] mask,
  input  logic [1:0] cur_sel,
  output logic [1:0] nxt_sel,
  output logic       wrap,
  output logic       none_set
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    nxt_sel = cur_sel;
    found   = 1'b0;
    idx     = cur_sel;
    // Offset 4 lands back on cur_sel, covering the single-channel case.
    for (int i = 1; i <= 4; i++) begin
      idx = cur_sel + 2'(i);
      if (!found && mask[idx]) begin
        nxt_sel = idx;
        found   = 1'b1;
      end
    end
    none_set = (mask == 4'b0000);
    wrap     = !none_set && (nxt_sel <= cur_sel);
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scans enabled channels of a 2x4 decoder: blank period, then dwell, per channel.
// All outputs registered (one clock from inputs); no backpressure, stop aborts at once.
module decoder_scan_ctrl
  import decoder_scan_ctrl_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = DWELL_CYCLES_DEF,
  parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] mask,
  output logic [1:0] sel,
  output logic       enable,
  output logic       busy,
  output logic       wrap
);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             enable_q, enable_d;
  logic             busy_q, busy_d;
  logic             wrap_q, wrap_d;

  logic [1:0]       pick_cur;
  logic [1:0]       pick_sel;
  logic             pick_wrap;
  logic             pick_none;

  // Searching upward from 3 yields the lowest set bit, reused for the start case.
  assign pick_cur = (state_q == IDLE) ? 2'd3 : sel_q;

  next_channel_pick u_pick (
    .mask     (mask),
    .cur_sel  (pick_cur),
    .nxt_sel  (pick_sel),
    .wrap     (pick_wrap),
    .none_set (pick_none)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop && !pick_none) begin
          state_d = BLANK;
          cnt_d   = '0;
          sel_d   = pick_sel;
        end
      end
      BLANK: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = DWELL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DWELL: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (pick_none) begin
            state_d = IDLE;
          end else begin
            state_d = BLANK;
            sel_d   = pick_sel;
            wrap_d  = pick_wrap;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    enable_d = (state_d == DWELL);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= 2'd0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      wrap_q   <= wrap_d;
    end
  end

  assign sel    = sel_q;
  assign enable = enable_q;
  assign busy   = busy_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl with default parameters.
module tb_decoder_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [3:0] mask;
  logic [1:0] sel;
  logic       enable;
  logic       busy;
  logic       wrap;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0]      mask;
    logic [5:0][1:0] exp_sel;
    logic [5:0]      exp_wrap;
  } scan_vec_t;

  scan_vec_t vecs [6];

  decoder_scan_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .mask   (mask),
    .sel    (sel),
    .enable (enable),
    .busy   (busy),
    .wrap   (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Expected channel order and wrap pulses for six consecutive steps (index 0 first).
    vecs[0] = '{mask: 4'b1111, exp_sel: {2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0}, exp_wrap: 6'b010000};
    vecs[1] = '{mask: 4'b1010, exp_sel: {2'd3, 2'd1, 2'd3, 2'd1, 2'd3, 2'd1}, exp_wrap: 6'b010100};
    vecs[2] = '{mask: 4'b0100, exp_sel: {2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2}, exp_wrap: 6'b111110};
    vecs[3] = '{mask: 4'b1001, exp_sel: {2'd3, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0}, exp_wrap: 6'b010100};
    vecs[4] = '{mask: 4'b0110, exp_sel: {2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1}, exp_wrap: 6'b010100};
    vecs[5] = '{mask: 4'b1000, exp_sel: {2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3}, exp_wrap: 6'b111110};

    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    mask  = 4'b0000;
    #3;
    check("rst_sel", 8'(sel), 8'd0);
    check("rst_enable", 8'(enable), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_wrap", 8'(wrap), 8'd0);
    tick();
    tick();

    // Start in the same cycle rst drops is honoured on the first edge.
    rst   = 1'b0;
    mask  = 4'b1100;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("first_edge_busy", 8'(busy), 8'd1);
    check("first_edge_sel", 8'(sel), 8'd2);
    check("first_edge_enable", 8'(enable), 8'd0);

    foreach (vecs[v]) begin
      do_reset();
      mask = vecs[v].mask;
      pulse_start();
      for (int k = 0; k < 6; k++) begin
        for (int c = 0; c < 10; c++) begin
          check($sformatf("scan%0d_step%0d_c%0d_sel", v, k, c), 8'(sel), 8'(vecs[v].exp_sel[k]));
          check($sformatf("scan%0d_step%0d_c%0d_enable", v, k, c), 8'(enable), (c >= 2) ? 8'd1 : 8'd0);
          check($sformatf("scan%0d_step%0d_c%0d_busy", v, k, c), 8'(busy), 8'd1);
          check($sformatf("scan%0d_step%0d_c%0d_wrap", v, k, c), 8'(wrap),
                (c == 0) ? 8'(vecs[v].exp_wrap[k]) : 8'd0);
          tick();
        end
      end
    end

    // Start with an empty mask.
    do_reset();
    mask = 4'b0000;
    pulse_start();
    check("empty_start_busy", 8'(busy), 8'd0);
    tick();
    check("empty_start_busy2", 8'(busy), 8'd0);
    check("empty_start_enable", 8'(enable), 8'd0);

    // Start and stop together in IDLE.
    mask  = 4'b1111;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_busy", 8'(busy), 8'd0);
    tick();
    check("start_stop_busy2", 8'(busy), 8'd0);

    // Stop during BLANK.
    do_reset();
    mask = 4'b1010;
    pulse_start();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_blank_busy", 8'(busy), 8'd0);
    check("stop_blank_sel", 8'(sel), 8'd1);

    // Stop on the 4th dwell clock.
    do_reset();
    mask = 4'b1010;
    pulse_start();
    tick();
    tick();
    check("stop_dwell_pre_enable", 8'(enable), 8'd1);
    tick();
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_dwell_enable", 8'(enable), 8'd0);
    check("stop_dwell_busy", 8'(busy), 8'd0);
    check("stop_dwell_sel", 8'(sel), 8'd1);
    tick();
    tick();
    check("stop_dwell_sel_held", 8'(sel), 8'd1);
    check("stop_dwell_enable_held", 8'(enable), 8'd0);

    // Stop beats the end-of-dwell advance on the 3->1 wrap.
    do_reset();
    mask = 4'b1010;
    pulse_start();
    for (int i = 0; i < 19; i++) tick();
    check("stop_last_pre_sel", 8'(sel), 8'd3);
    check("stop_last_pre_enable", 8'(enable), 8'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_last_busy", 8'(busy), 8'd0);
    check("stop_last_sel", 8'(sel), 8'd3);
    check("stop_last_wrap", 8'(wrap), 8'd0);
    check("stop_last_enable", 8'(enable), 8'd0);

    // Mask cleared during the dwell on channel 2.
    do_reset();
    mask = 4'b0100;
    pulse_start();
    tick();
    tick();
    mask = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("mask_clr_d%0d_enable", i), 8'(enable), 8'd1);
      check($sformatf("mask_clr_d%0d_sel", i), 8'(sel), 8'd2);
      tick();
    end
    check("mask_clr_end_enable", 8'(enable), 8'd0);
    check("mask_clr_end_busy", 8'(busy), 8'd0);
    check("mask_clr_end_sel", 8'(sel), 8'd2);

    // Asynchronous reset between edges mid-dwell.
    do_reset();
    mask = 4'b0110;
    pulse_start();
    tick();
    tick();
    tick();
    check("arst_pre_enable", 8'(enable), 8'd1);
    check("arst_pre_sel", 8'(sel), 8'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_enable", 8'(enable), 8'd0);
    check("arst_sel", 8'(sel), 8'd0);
    check("arst_busy", 8'(busy), 8'd0);
    tick();
    rst = 1'b0;
    tick();
    check("arst_idle_busy", 8'(busy), 8'd0);
    pulse_start();
    check("arst_resume_sel", 8'(sel), 8'd1);
    check("arst_resume_busy", 8'(busy), 8'd1);
    check("arst_resume_enable", 8'(enable), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
